// File: rtl/human_brain_pkg.sv
// -----------------------------------------------------------------------------
// human_brain_pkg
// Shared widths and types for the two-input neuron datapath.
//   DATA_W  : width of inputs, weights, threshold and activated output
//   PROD_W  : full width of one input*weight product (no truncation)
//   SUM_W   : full width of the sum of two products (max 450, never overflows)
//   OUT_MAX : saturation ceiling of the activated output
// -----------------------------------------------------------------------------
package human_brain_pkg;

   localparam int          DATA_W  = 4;
   localparam int          PROD_W  = 2 * DATA_W;
   localparam int          SUM_W   = PROD_W + 1;
   localparam logic [3:0]  OUT_MAX = 4'hF;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [PROD_W-1:0] prod_t;
   typedef logic [SUM_W-1:0]  sum_t;

endpackage : human_brain_pkg

// File: rtl/neuron_activation.sv
// -----------------------------------------------------------------------------
// neuron_activation
// Combinational threshold-offset ReLU with saturation:
//   out = 0                  when sum <= thresh
//   out = min(sum - thresh, OUT_MAX) otherwise
// Ports:
//   i_sum    in  SUM_W   weighted sum, unsigned
//   i_thresh in  DATA_W  activation threshold, unsigned
//   o_act    out DATA_W  activated, saturated result
// -----------------------------------------------------------------------------
module neuron_activation
   import human_brain_pkg::*;
(
   input  logic [SUM_W-1:0]  i_sum,
   input  logic [DATA_W-1:0] i_thresh,
   output logic [DATA_W-1:0] o_act
);

   sum_t w_thresh_ext;
   sum_t w_diff;

   assign w_thresh_ext = sum_t'(i_thresh);
   // Only meaningful when i_sum > threshold; otherwise the ReLU floor wins.
   assign w_diff       = i_sum - w_thresh_ext;

   always_comb begin
      o_act = '0;
      if (i_sum > w_thresh_ext) begin
         if (w_diff > sum_t'(OUT_MAX)) begin
            o_act = OUT_MAX;
         end else begin
            o_act = w_diff[DATA_W-1:0];
         end
      end
   end

endmodule : neuron_activation

// File: rtl/human_brain.sv
// -----------------------------------------------------------------------------
// human_brain
// Single two-input artificial neuron, fully pipelined (2-cycle latency,
// one sample per clock, no handshake).
//   Stage 1: p1 = inp1*w1, p2 = inp2*w2, threshold delayed alongside.
//   Stage 2: out = sat4(relu(p1 + p2 - t)).
// Ports (order is relied on by positional instantiation elsewhere):
//   inp1  in  4  neuron input 1
//   inp2  in  4  neuron input 2
//   clock in  1  rising-edge clock
//   w1    in  4  weight for inp1
//   w2    in  4  weight for inp2
//   out   out 4  activated output, registered
//   res   in  1  synchronous active-high reset
//   t     in  4  activation threshold
// -----------------------------------------------------------------------------
module human_brain
   import human_brain_pkg::*;
(
   input  logic [3:0] inp1,
   input  logic [3:0] inp2,
   input  logic       clock,
   input  logic [3:0] w1,
   input  logic [3:0] w2,
   output logic [3:0] out,
   input  logic       res,
   input  logic [3:0] t
);

   // Stage-1 registers
   prod_t r_p1;
   prod_t r_p2;
   data_t r_t_q;
   // Stage-2 register
   data_t r_out;

   sum_t  w_sum;
   data_t w_act;

   always_ff @(posedge clock) begin
      if (res) begin
         // Inputs on a reset edge are dropped; zeros in stage 1 make the
         // following edge also produce 0 (sum 0 <= t_q 0).
         r_p1  <= '0;
         r_p2  <= '0;
         r_t_q <= '0;
      end else begin
         r_p1  <= prod_t'(inp1) * prod_t'(w1);
         r_p2  <= prod_t'(inp2) * prod_t'(w2);
         r_t_q <= t;
      end
   end

   // Full-width add: 225 + 225 fits in SUM_W bits.
   assign w_sum = sum_t'(r_p1) + sum_t'(r_p2);

   neuron_activation u_act (
      .i_sum    (w_sum),
      .i_thresh (r_t_q),
      .o_act    (w_act)
   );

   always_ff @(posedge clock) begin
      if (res) begin
         r_out <= '0;
      end else begin
         r_out <= w_act;
      end
   end

   assign out = r_out;

endmodule : human_brain

// File: tb/tb_human_brain.sv
// -----------------------------------------------------------------------------
// tb_human_brain
// Directed and random stimulus for the two-input neuron, checked every edge
// against an arithmetic reference: out(k) = res(k) ? 0 : f(sample(k-1)),
// where a sample taken under reset contributes 0.
// -----------------------------------------------------------------------------
module tb_human_brain;

   logic       clock = 1'b0;
   logic       res   = 1'b1;
   logic [3:0] inp1  = '0;
   logic [3:0] inp2  = '0;
   logic [3:0] w1    = '0;
   logic [3:0] w2    = '0;
   logic [3:0] t     = '0;
   logic [3:0] out;

   int vectors     = 0;
   int miscompares = 0;
   int pend        = 0;   // expected result of the sample now in stage 1
   int exp_out     = 0;

   human_brain dut (
      .inp1  (inp1),
      .inp2  (inp2),
      .clock (clock),
      .w1    (w1),
      .w2    (w2),
      .out   (out),
      .res   (res),
      .t     (t)
   );

   always #5 clock = ~clock;

   // Neuron transfer function from plain integer arithmetic.
   function automatic int neuron(input int a, input int wa, input int b,
                                 input int wb, input int th);
      int d;
      d = a * wa + b * wb - th;
      if (d <= 0)  return 0;
      if (d > 15)  return 15;
      return d;
   endfunction

   // Present one sample, clock it in, then check out just after the edge.
   task automatic step(input int a, input int wa, input int b, input int wb,
                       input int th, input bit rst, input string tag);
      inp1 = 4'(a);
      w1   = 4'(wa);
      inp2 = 4'(b);
      w2   = 4'(wb);
      t    = 4'(th);
      res  = rst;
      @(posedge clock);
      #1;
      exp_out = rst ? 0 : pend;
      pend    = rst ? 0 : neuron(a, wa, b, wb, th);
      vectors++;
      assert (out === 4'(exp_out)) else begin
         miscompares++;
         $error("FAIL %s: out=%0d expected=%0d", tag, out, exp_out);
      end
      $display("step %-10s in=(%0d*%0d + %0d*%0d) t=%0d res=%0d -> out=%0d exp=%0d",
               tag, a, wa, b, wb, th, rst, out, exp_out);
   endtask

   initial begin
      // Reset held for 2 edges with nonzero inputs, then release.
      step(9, 9, 7, 7, 1, 1'b1, "reset0");
      step(5, 6, 3, 2, 0, 1'b1, "reset1");
      // Saturation: sum 22, t=0 -> 15 (first edge after release still 0).
      step(3, 4, 2, 5, 0, 1'b0, "rel0");
      // Threshold offset family: sum 5 with t=2,5,6.
      step(1, 2, 1, 3, 2, 1'b0, "sat22");
      step(1, 2, 1, 3, 5, 1'b0, "thr_t2");
      step(1, 2, 1, 3, 6, 1'b0, "thr_eq");
      // Back-to-back with t changing each cycle.
      step(1, 1, 1, 1, 0, 1'b0, "thr_t6");
      step(2, 2, 2, 2, 1, 1'b0, "b2b_2");
      step(0, 0, 0, 0, 0, 1'b0, "b2b_7");
      // Extremes.
      step(15, 15, 15, 15, 15, 1'b0, "b2b_0");
      step(0, 0, 0, 0, 0, 1'b0, "max450");
      step(4, 4, 0, 9, 1, 1'b0, "zeros");
      step(4, 4, 0, 0, 0, 1'b0, "d15");
      step(2, 8, 0, 0, 0, 1'b0, "d16");
      step(1, 1, 0, 0, 0, 1'b0, "d16b");
      // Mid-stream reset for one edge between valid samples.
      step(7, 7, 1, 1, 0, 1'b0, "pre_rst");
      step(3, 3, 3, 3, 3, 1'b1, "mid_rst");
      step(2, 3, 1, 1, 2, 1'b0, "post0");
      step(1, 5, 2, 2, 0, 1'b0, "post1");
      step(0, 0, 0, 0, 0, 1'b0, "post2");
      step(0, 0, 0, 0, 0, 1'b0, "post3");

      // Random traffic, small weights so many results fall inside 0..15,
      // with occasional one-edge resets.
      for (int i = 0; i < 200; i++) begin
         int a, b, wa, wb, th;
         bit rst;
         a   = int'($urandom_range(0, 15));
         b   = int'($urandom_range(0, 15));
         wa  = int'($urandom_range(0, (i % 2 == 0) ? 3 : 15));
         wb  = int'($urandom_range(0, (i % 2 == 0) ? 3 : 15));
         th  = int'($urandom_range(0, 15));
         rst = ($urandom_range(0, 19) == 0);
         step(a, wa, b, wb, th, rst, "rand");
      end
      // Drain the pipeline.
      step(0, 0, 0, 0, 0, 1'b0, "drain0");
      step(0, 0, 0, 0, 0, 1'b0, "drain1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_human_brain
